// File: rtl/sd_block_receiver_pkg.sv
// Shared constants, state encoding and the serial CRC16-CCITT step used by
// the SD SPI block receiver and its sibling transmit-side CRC generator.
package sd_block_receiver_pkg;

  localparam logic [7:0]  START_TOKEN = 8'hFE;
  localparam logic [15:0] CRC16_POLY  = 16'h1021;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    DATA,
    CRC
  } rx_state_e;

  // One MSB-first step of CRC16-CCITT: feedback is the outgoing MSB xor the new bit.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC16-CCITT accumulator (init 0). 'clear' wins over 'en'.
module crc16_serial
  import sd_block_receiver_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clear,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;

  // Accumulate one data bit per enabled cycle; restart from zero on clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      crc_q <= 16'h0000;
    end else if (clear) begin
      crc_q <= 16'h0000;
    end else if (en) begin
      crc_q <= crc16_next(crc_q, bit_in);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_block_receiver.sv
// SD SPI receive-side data-block engine: hunts the bit-aligned 0xFE token,
// deserialises BLOCK_BYTES bytes MSB-first, captures the trailing CRC16 and
// compares it with the CRC computed over the received data bits.
module sd_block_receiver
  import sd_block_receiver_pkg::*;
#(
  parameter int BLOCK_BYTES  = 512,
  parameter int TIMEOUT_BITS = 4096
) (
  input  logic                           spi_clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           start,
  input  logic                           miso,
  output logic [7:0]                     data,
  output logic                           data_valid,
  output logic [$clog2(BLOCK_BYTES)-1:0] byte_index,
  output logic                           busy,
  output logic                           done,
  output logic                           crc_ok,
  output logic                           crc_err,
  output logic                           timeout,
  output logic [15:0]                    crc16_calc,
  output logic [15:0]                    crc16_rx
);

  localparam int IDX_W = $clog2(BLOCK_BYTES);
  localparam int TMO_W = $clog2(TIMEOUT_BITS);

  rx_state_e        state_q, state_d;
  logic [7:0]       window_q, window_d;
  logic [7:0]       shift_q, shift_d;
  logic [TMO_W-1:0] hunt_cnt_q, hunt_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic [IDX_W-1:0] byte_index_q, byte_index_d;
  logic             done_q, done_d;
  logic             crc_ok_q, crc_ok_d;
  logic             crc_err_q, crc_err_d;
  logic             timeout_q, timeout_d;
  logic [15:0]      crc_rx_q, crc_rx_d;
  logic             crc_clear, crc_step;
  logic [7:0]       win_next, byte_next;
  logic [15:0]      rx_next;

  crc16_serial u_crc (
    .clk    (spi_clk),
    .reset  (reset),
    .en     (crc_step),
    .clear  (crc_clear),
    .bit_in (miso),
    .crc    (crc16_calc)
  );

  // Next-state and output decode; every register holds unless a rule changes it.
  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    shift_d      = shift_q;
    hunt_cnt_d   = hunt_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    byte_index_d = byte_index_q;
    done_d       = 1'b0;
    crc_ok_d     = crc_ok_q;
    crc_err_d    = crc_err_q;
    timeout_d    = timeout_q;
    crc_rx_d     = crc_rx_q;
    crc_clear    = 1'b0;
    crc_step     = 1'b0;
    win_next     = {window_q[6:0], miso};
    byte_next    = {shift_q[6:0], miso};
    rx_next      = {crc_rx_q[14:0], miso};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = HUNT;
          window_d   = 8'h00;
          shift_d    = 8'h00;
          hunt_cnt_d = '0;
          bit_cnt_d  = 4'd0;
          byte_cnt_d = '0;
          crc_ok_d   = 1'b0;
          crc_err_d  = 1'b0;
          timeout_d  = 1'b0;
          crc_rx_d   = 16'h0000;
          crc_clear  = 1'b1;
        end
      end
      HUNT: begin
        if (en) begin
          window_d = win_next;
          if (win_next == START_TOKEN) begin
            state_d    = DATA;
            bit_cnt_d  = 4'd0;
            byte_cnt_d = '0;
          end else if (hunt_cnt_q == TMO_W'(TIMEOUT_BITS - 1)) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            hunt_cnt_d = hunt_cnt_q + TMO_W'(1);
          end
        end
      end
      DATA: begin
        if (en) begin
          crc_step = 1'b1;
          shift_d  = byte_next;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d    = 4'd0;
            data_d       = byte_next;
            data_valid_d = 1'b1;
            byte_index_d = byte_cnt_q;
            byte_cnt_d   = byte_cnt_q + IDX_W'(1);
            if (byte_cnt_q == IDX_W'(BLOCK_BYTES - 1)) begin
              state_d = CRC;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      CRC: begin
        if (en) begin
          crc_rx_d = rx_next;
          if (bit_cnt_q == 4'd15) begin
            crc_ok_d  = (rx_next == crc16_calc);
            crc_err_d = (rx_next != crc16_calc);
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge spi_clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      window_q     <= 8'h00;
      shift_q      <= 8'h00;
      hunt_cnt_q   <= '0;
      bit_cnt_q    <= 4'd0;
      byte_cnt_q   <= '0;
      data_q       <= 8'h00;
      data_valid_q <= 1'b0;
      byte_index_q <= '0;
      done_q       <= 1'b0;
      crc_ok_q     <= 1'b0;
      crc_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
      crc_rx_q     <= 16'h0000;
    end else begin
      state_q      <= state_d;
      window_q     <= window_d;
      shift_q      <= shift_d;
      hunt_cnt_q   <= hunt_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      byte_index_q <= byte_index_d;
      done_q       <= done_d;
      crc_ok_q     <= crc_ok_d;
      crc_err_q    <= crc_err_d;
      timeout_q    <= timeout_d;
      crc_rx_q     <= crc_rx_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign byte_index = byte_index_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign crc_ok     = crc_ok_q;
  assign crc_err    = crc_err_q;
  assign timeout    = timeout_q;
  assign crc16_rx   = crc_rx_q;

endmodule

// File: tb/tb_sd_block_receiver.sv
// Bench for sd_block_receiver: drives whole SD blocks bit by bit and compares
// the observed byte strobes and result flags against a byte-level model.
module tb_sd_block_receiver;

  localparam int BLOCK_BYTES  = 512;
  localparam int TIMEOUT_BITS = 64;
  localparam logic [7:0] TOKEN = 8'hFE;

  logic        spi_clk = 1'b0;
  logic        reset, en, start, miso;
  logic [7:0]  data;
  logic        data_valid, busy, done, crc_ok, crc_err, timeout;
  logic [8:0]  byte_index;
  logic [15:0] crc16_calc, crc16_rx;

  int checks = 0;
  int failures = 0;

  logic [7:0] blockBytes[$];
  logic [7:0] dvData[$];
  int         dvIdx[$];
  int         dvPos[$];
  int         doneCount, strobeNoEn, strobeDouble, enBitCount, tokenEnd;
  logic       prevDv, doneAtEnd, busyAtEnd, busyAfterStart;

  sd_block_receiver #(.BLOCK_BYTES(BLOCK_BYTES), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
    .spi_clk    (spi_clk),
    .reset      (reset),
    .en         (en),
    .start      (start),
    .miso       (miso),
    .data       (data),
    .data_valid (data_valid),
    .byte_index (byte_index),
    .busy       (busy),
    .done       (done),
    .crc_ok     (crc_ok),
    .crc_err    (crc_err),
    .timeout    (timeout),
    .crc16_calc (crc16_calc),
    .crc16_rx   (crc16_rx)
  );

  // Free-running bit clock.
  always #5 spi_clk = ~spi_clk;

  // Hard stop in case the design never finishes a block.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  // One clock: apply inputs, let the edge happen, then record what came out.
  task automatic clockCycle(input logic enV, input logic misoV, input logic startV);
    en = enV;
    miso = misoV;
    start = startV;
    @(posedge spi_clk);
    #1;
    if (enV) enBitCount++;
    if (data_valid) begin
      dvData.push_back(data);
      dvIdx.push_back(int'(byte_index));
      dvPos.push_back(enBitCount);
      if (!enV) strobeNoEn++;
      if (prevDv) strobeDouble++;
    end
    prevDv = data_valid;
    if (done) doneCount++;
    start = 1'b0;
  endtask

  // One enabled bit, optionally preceded by an en-low cycle carrying junk.
  task automatic sendBit(input logic b, input bit gap, input logic startV);
    if (gap) clockCycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    clockCycle(1'b1, b, startV);
  endtask

  task automatic clearObs();
    dvData.delete();
    dvIdx.delete();
    dvPos.delete();
    doneCount = 0;
    strobeNoEn = 0;
    strobeDouble = 0;
  endtask

  task automatic fillBlock(input int mode, input logic [7:0] val);
    blockBytes.delete();
    for (int k = 0; k < BLOCK_BYTES; k++)
      blockBytes.push_back(mode == 0 ? val : 8'($urandom));
  endtask

  // Byte-at-a-time CRC16-CCITT (XMODEM form) over the whole data block.
  function automatic logic [15:0] modelCrc();
    logic [15:0] c;
    c = 16'h0000;
    foreach (blockBytes[k]) begin
      c = c ^ {blockBytes[k], 8'h00};
      for (int i = 0; i < 8; i++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Number of strobes whose byte, index or arrival bit-time disagrees with the block.
  function automatic int badBytes();
    int bad;
    bad = 0;
    for (int k = 0; k < dvData.size() && k < BLOCK_BYTES; k++)
      if (dvData[k] !== blockBytes[k] || dvIdx[k] != k || dvPos[k] != tokenEnd + 8 * (k + 1))
        bad++;
    return bad;
  endfunction

  // Start, leading ones, token, data, CRC; abortByte stops mid-byte, busyStartByte pulses start.
  task automatic runBlock(input int lead, input logic [15:0] crcV, input bit gap,
                          input int busyStartByte, input int abortByte);
    logic [7:0] cur;
    clearObs();
    clockCycle(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    busyAfterStart = busy;
    for (int i = 0; i < lead; i++) sendBit(1'b1, gap, 1'b0);
    for (int i = 7; i >= 0; i--) sendBit(TOKEN[i], gap, 1'b0);
    tokenEnd = enBitCount;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      cur = blockBytes[k];
      for (int b = 7; b >= 0; b--) begin
        if (k == abortByte && b == 3) return;
        sendBit(cur[b], gap, 1'(k == busyStartByte && b == 4));
      end
    end
    for (int b = 15; b >= 0; b--) sendBit(crcV[b], gap, 1'b0);
    doneAtEnd = done;
    busyAtEnd = busy;
    repeat (3) clockCycle(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) clockCycle(1'b1, 1'b1, 1'b0);
    checks++;
    if ({data, data_valid, byte_index, busy, done, crc_ok, crc_err, timeout, crc16_calc, crc16_rx} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got busy=%b done=%b calc=%h rx=%h data=%h want all zero",
               busy, done, crc16_calc, crc16_rx, data);
    end
    reset = 1'b1;
    clockCycle(1'b1, 1'b1, 1'b0);
  endtask

  // Shared result comparisons for one completed block; name tags the scenario.
  task automatic test_block(input string name, input int lead, input int mode, input logic [7:0] val,
                            input logic [15:0] crcV, input bit gap, input int busyStartByte);
    logic [15:0] model;
    logic        wantOk;
    fillBlock(mode, val);
    model = modelCrc();
    wantOk = (crcV == model);
    runBlock(lead, crcV, gap, busyStartByte, -1);
    checks++;
    if (busyAfterStart !== 1'b1) begin failures++; $display("[TB] FAIL %s busy_after_start got=%b want=1", name, busyAfterStart); end
    checks++;
    if (dvData.size() != BLOCK_BYTES) begin failures++; $display("[TB] FAIL %s dv_count got=%0d want=%0d", name, dvData.size(), BLOCK_BYTES); end
    checks++;
    if (badBytes() != 0) begin failures++; $display("[TB] FAIL %s byte_stream bad=%0d want=0", name, badBytes()); end
    checks++;
    if (strobeNoEn != 0 || strobeDouble != 0) begin
      failures++; $display("[TB] FAIL %s strobe_shape noEn=%0d double=%0d want=0/0", name, strobeNoEn, strobeDouble);
    end
    checks++;
    if (doneAtEnd !== 1'b1 || busyAtEnd !== 1'b0) begin
      failures++; $display("[TB] FAIL %s done_timing done=%b busy=%b want done=1 busy=0", name, doneAtEnd, busyAtEnd);
    end
    checks++;
    if (doneCount != 1) begin failures++; $display("[TB] FAIL %s done_count got=%0d want=1", name, doneCount); end
    checks++;
    if (crc16_calc !== model) begin failures++; $display("[TB] FAIL %s crc16_calc got=%h want=%h", name, crc16_calc, model); end
    checks++;
    if (crc16_rx !== crcV) begin failures++; $display("[TB] FAIL %s crc16_rx got=%h want=%h", name, crc16_rx, crcV); end
    checks++;
    if ({crc_ok, crc_err, timeout} !== {wantOk, ~wantOk, 1'b0}) begin
      failures++; $display("[TB] FAIL %s flags ok/err/tmo got=%b%b%b want=%b%b0", name, crc_ok, crc_err, timeout, wantOk, ~wantOk);
    end
  endtask

  task automatic test_full_block();
    test_block("full_ff", 8, 0, 8'hFF, 16'h7FA1, 1'b0, -1);
  endtask

  task automatic test_corrupted_crc();
    test_block("bad_crc", 8, 0, 8'hFF, 16'h7FA0, 1'b0, -1);
  endtask

  task automatic test_zero_block();
    test_block("zero_bitalign", 11, 0, 8'h00, 16'h0000, 1'b0, -1);
  endtask

  task automatic test_gapped_enable();
    test_block("gapped", 8, 0, 8'hFF, 16'h7FA1, 1'b1, -1);
  endtask

  task automatic test_random_blocks();
    logic [15:0] c;
    for (int n = 0; n < 2; n++) begin
      fillBlock(1, 8'h00);
      c = modelCrc();
      if ($urandom_range(0, 1) == 1) c = c ^ (16'h0001 << $urandom_range(0, 15));
      test_block("random", int'($urandom_range(0, 7)), 2, 8'h00, c, 1'($urandom_range(0, 1)), -1);
    end
  endtask

  task automatic test_timeout();
    clearObs();
    clockCycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < TIMEOUT_BITS - 1; i++) clockCycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (doneCount != 0 || busy !== 1'b1) begin
      failures++; $display("[TB] FAIL timeout_early done_count=%0d busy=%b want 0/1", doneCount, busy);
    end
    clockCycle(1'b1, 1'b1, 1'b0);
    checks++;
    if ({done, timeout, busy, crc_ok, crc_err} !== 5'b11000) begin
      failures++; $display("[TB] FAIL timeout_fire done/tmo/busy/ok/err got=%b%b%b%b%b want=11000", done, timeout, busy, crc_ok, crc_err);
    end
    clockCycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (done !== 1'b0 || timeout !== 1'b1 || dvData.size() != 0) begin
      failures++; $display("[TB] FAIL timeout_hold done=%b timeout=%b dv=%0d want 0/1/0", done, timeout, dvData.size());
    end
  endtask

  task automatic test_reset_rearm();
    fillBlock(0, 8'hFF);
    runBlock(8, 16'h7FA1, 1'b0, -1, 100);
    reset = 1'b0;
    clockCycle(1'b1, 1'b1, 1'b0);
    checks++;
    if ({data, data_valid, byte_index, busy, done, crc_ok, crc_err, timeout, crc16_calc, crc16_rx} !== '0 || doneCount != 0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got busy=%b done=%b calc=%h data=%h idx=%0d dones=%0d want all zero",
               busy, done, crc16_calc, data, byte_index, doneCount);
    end
    reset = 1'b1;
    clockCycle(1'b0, 1'b1, 1'b0);
    test_block("rearm_busy_start", 8, 0, 8'hFF, 16'h7FA1, 1'b0, 50);
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    start = 1'b0;
    miso = 1'b1;
    prevDv = 1'b0;
    enBitCount = 0;
    tokenEnd = 0;
    clearObs();
    test_reset();
    test_full_block();
    test_corrupted_crc();
    test_zero_block();
    test_timeout();
    test_gapped_enable();
    test_random_blocks();
    test_reset_rearm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_block_receiver.md
# sd_block_receiver

Receive-side SD SPI data-block engine. Hunts the MISO bit stream for the 0xFE start-block token, deserialises a fixed-length data block MSB-first, captures the trailing 16-bit CRC and checks it against a CRC16-CCITT computed over the received data bits. It sits beside `crc_manager`, which generates CRC over outgoing MOSI bits; this block checks incoming MISO blocks and feeds bytes to the cart-side buffer logic.

## Interface
- `BLOCK_BYTES`, 512: data bytes per block.
- `TIMEOUT_BITS`, 4096: enabled bit-times allowed in HUNT before giving up.
- `spi_clk` in 1: the single clock; all state advances on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `en` in 1: bit-enable; state advances and `miso` is sampled only when high.
- `start` in 1: one-cycle arm pulse, honoured only in IDLE.
- `miso` in 1: serial data from card.
- `data` out 8: last completed byte.
- `data_valid` out 1: one-cycle strobe, `data` valid.
- `byte_index` out clog2(BLOCK_BYTES): index of the byte on `data`.
- `busy` out 1: high in HUNT, DATA and CRC.
- `done` out 1: one-cycle pulse at block end or timeout.
- `crc_ok`, `crc_err`, `timeout` out 1: sticky result flags.
- `crc16_calc`, `crc16_rx` out 16: computed and received CRC values.

## Operation
- All outputs reset to 0; state resets to IDLE.
- States:
  - IDLE: `start` clears all result flags, the CRC registers and the counters, then moves to HUNT.
  - HUNT: shift `miso` into an 8-bit sliding window on each `en`. When window == 0xFE, go to DATA with the bit counter at 0. The token is bit-aligned, not byte-aligned. Count bits; the TIMEOUT_BITS-th bit without a token sets `timeout`=1 and pulses `done`, then returns to IDLE.
  - DATA: each enabled bit shifts into the byte register and steps the CRC (poly 0x1021, init 0x0000, MSB first, data bits only). Every 8th bit loads `data`, pulses `data_valid` and drives `byte_index`. After byte BLOCK_BYTES-1, go to CRC.
  - CRC: shift 16 bits MSB-first into `crc16_rx`; the CRC engine does not step. On the 16th bit set `crc_ok` = (`crc16_rx` == `crc16_calc`), set `crc_err` = its inverse, pulse `done`, and return to IDLE.
- `crc_ok`, `crc_err`, `timeout` and `crc16_*` hold until the next accepted `start`.
- `start` is ignored while `busy`.
- `en` low: no sampling, no counting, no strobes; all state holds.
- At most one of `crc_ok`, `crc_err`, `timeout` is set at a time.

## Timing
- The bit sampled on the enabled cycle k is visible in registers at cycle k+1.
- `data_valid` and `data` are registered. Both assert the cycle after the en-cycle that sampled bit 7 of the byte.
- `done` and the result flags assert together, the cycle after the last CRC bit is sampled. `busy` drops in that same cycle.
- Token to first `data_valid`: 8 enabled bits.
- `start` to HUNT: 1 cycle. A bit sampled in that same cycle is not part of the hunt.
- Reset low mid-operation: IDLE and all outputs 0 on the next edge. No `done` is pulsed.

## Structure
- Shared package:
  - token constant 0xFE;
  - CRC16 polynomial 0x1021;
  - state enum IDLE/HUNT/DATA/CRC;
  - a `crc16_next(crc, bit)` function shared with `crc_manager`.
- Sub-module: `crc16_serial` (en, clear, bit_in, crc[15:0]). This module is instantiated here and is reusable by `crc_manager`.
- The FSM, counters and shift registers live in the top module.

## Test plan
- Full block, good CRC. Stimulus: `start`, 8×'1', 0xFE, 512×0xFF, CRC 0x7FA1. Response:
  - 512 `data_valid` with `data`=0xFF and `byte_index` 0..511;
  - `done`, `crc_ok`=1, `crc16_calc`=0x7FA1.
- Corrupted CRC. Same block but CRC 0x7FA0. Response: `crc_err`=1, `crc_ok`=0, `crc16_rx`=0x7FA0, `crc16_calc`=0x7FA1.
- All-zero block. 512×0x00 with CRC 0x0000. Response: `crc_ok`=1. Also precede the token with 3 extra '1' bits to confirm bit-aligned hunting.
- Timeout. With TIMEOUT_BITS=64 and `miso` held at 1, `start` gives `timeout`=1 and a `done` pulse after 64 enabled bits, with no `data_valid`.
- Gapped enable. Repeat the first scenario with `en` high every other cycle. Results must be identical, with no strobes in `en`-low cycles.
- Reset and re-arm:
  - `reset` low during byte 100: all outputs 0 on the next edge, state IDLE;
  - a fresh `start` then runs the first scenario correctly;
  - `start` pulsed while `busy` has no effect.
